// File: rtl/relu_pkg.sv
// Shared ReLU definitions: default data format, backward FSM states and the positive-mask rule.
// Used by both the forward activation and the backward gradient mask.
package relu_pkg;

   localparam int RELU_N = 32;
   localparam int RELU_Q = 15;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_BACKPROP = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Strictly positive: sign clear and not all-zero.
   function automatic logic relu_pos(input logic [RELU_N-1:0] x);
      return ~x[RELU_N-1] & (|x);
   endfunction

endpackage

// File: rtl/relu_mask_buf.sv
// DEPTH x 1 mask store: one synchronous write port and one asynchronous read port.
// Zero read latency, no flow control; the array itself is never reset.
module relu_mask_buf #(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic          i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic          o_rdata
);

   logic [DEPTH-1:0] r_mem;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/relu_backward_stream.sv
// ReLU backward: captures a positive mask per forward element, then passes or zeroes each gradient.
// One cycle gradient-to-output latency; grad_ready drops while a held output is stalled downstream.
module relu_backward_stream
   import relu_pkg::*;
#(
   parameter int Q     = RELU_Q,
   parameter int N     = RELU_N,
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             fwd_valid,
   output logic             fwd_ready,
   input  logic [N-1:0]     fwd_x,
   input  logic             grad_valid,
   output logic             grad_ready,
   input  logic [N-1:0]     grad_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_grad,
   output logic             busy,
   output logic             done,
   output logic             err_len
);

   localparam int AW = $clog2(DEPTH);

   if (Q < 0 || Q >= N || DEPTH < 2 || (1 << AW) != DEPTH) begin : g_cfg_chk
      $error("relu_backward_stream: illegal Q/N/DEPTH combination");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_wr_cnt;
   logic [CNT_W-1:0] r_rd_cnt;
   logic             r_out_valid;
   logic [N-1:0]     r_out_grad;
   logic             r_err_len;
   logic             w_len_ok;
   logic             w_start_ok;
   logic             w_fwd_xfer;
   logic             w_grad_xfer;
   logic             w_out_free;
   logic             w_buf_rdata;

   assign w_len_ok    = (len != '0) && (len <= CNT_W'(DEPTH));
   assign w_start_ok  = (r_state == ST_IDLE) && start && w_len_ok;
   assign w_fwd_xfer  = fwd_valid && fwd_ready;
   assign w_grad_xfer = grad_valid && grad_ready;
   // Output slot can take a new load if empty or being drained this cycle.
   assign w_out_free  = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      fwd_ready   = 1'b0;
      grad_ready  = 1'b0;
      done        = 1'b0;
      busy        = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_start_ok) begin
               w_state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            fwd_ready = 1'b1;
            if (fwd_valid && (r_wr_cnt + CNT_W'(1) == r_len)) begin
               w_state_nxt = ST_BACKPROP;
            end
         end
         ST_BACKPROP: begin
            grad_ready = (r_rd_cnt < r_len) && w_out_free;
            if ((r_rd_cnt == r_len) && w_out_free) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len    <= '0;
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else begin
         if (w_start_ok) begin
            r_len    <= len;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
         end
         if (w_fwd_xfer) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
         end
         if (w_grad_xfer) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
         end
      end
   end

   relu_mask_buf #(
      .DEPTH (DEPTH)
   ) u_mask_buf (
      .clk     (clk),
      .i_we    (w_fwd_xfer),
      .i_waddr (r_wr_cnt[AW-1:0]),
      .i_wdata (relu_pos(fwd_x)),
      .i_raddr (r_rd_cnt[AW-1:0]),
      .o_rdata (w_buf_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_grad  <= '0;
         r_err_len   <= 1'b0;
      end else begin
         r_err_len <= (r_state == ST_IDLE) && start && !w_len_ok;
         if (w_grad_xfer) begin
            r_out_valid <= 1'b1;
            r_out_grad  <= w_buf_rdata ? grad_in : '0;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_grad  = r_out_grad;
   assign err_len   = r_err_len;

endmodule

// File: tb/tb_relu_backward_stream.sv
// Directed bench for relu_backward_stream: a negedge monitor models the mask and scores every output.
module tb_relu_backward_stream;

   localparam int N     = 32;
   localparam int DEPTH = 64;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             fwd_valid;
   logic             fwd_ready;
   logic [N-1:0]     fwd_x;
   logic             grad_valid;
   logic             grad_ready;
   logic [N-1:0]     grad_in;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_grad;
   logic             busy;
   logic             done;
   logic             err_len;

   relu_backward_stream #(.Q(15), .N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .fwd_valid  (fwd_valid),
      .fwd_ready  (fwd_ready),
      .fwd_x      (fwd_x),
      .grad_valid (grad_valid),
      .grad_ready (grad_ready),
      .grad_in    (grad_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_grad   (out_grad),
      .busy       (busy),
      .done       (done),
      .err_len    (err_len)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: mask model from the forward stream, expected outputs from gradient handshakes.
   logic         mq[$];
   logic [N-1:0] eq[$];
   int           fwd_n = 0, grad_n = 0, out_n = 0, done_n = 0;
   int           streak = 0, last_out = -10;
   logic         prev_stall = 1'b0;
   logic [N-1:0] held = '0;
   logic         m;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         eq.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_vld", 32'(out_valid), 32'd1);
            chk("hold_dat", out_grad, held);
         end
         if (out_valid && !out_ready) chk("stall_grad_rdy", 32'(grad_ready), 32'd0);
         prev_stall = out_valid && !out_ready;
         held       = out_grad;
         if (fwd_valid && fwd_ready) begin
            fwd_n++;
            mq.push_back($signed(fwd_x) > 0);
         end
         if (grad_valid && grad_ready) begin
            grad_n++;
            if (mq.size() == 0) chk("grad_extra", 32'(grad_ready), 32'd0);
            else begin
               m = mq.pop_front();
               eq.push_back(m ? grad_in : '0);
            end
         end
         if (out_valid && out_ready) begin
            out_n++;
            streak   = (last_out == cyc - 1) ? streak + 1 : 1;
            last_out = cyc;
            if (eq.size() == 0) chk("out_extra", 32'(out_valid), 32'd0);
            else chk("out_grad", out_grad, eq.pop_front());
         end
         if (done) done_n++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fwd_rdy"}, 32'(fwd_ready), 32'd0);
      chk({tag, "_grad_rdy"}, 32'(grad_ready), 32'd0);
      chk({tag, "_out_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_grad"}, out_grad, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err_len"}, 32'(err_len), 32'd0);
   endtask

   task automatic do_start(input logic [CNT_W-1:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic push_fwd(input logic [N-1:0] x);
      int g = 0;
      fwd_valid = 1'b1;
      fwd_x     = x;
      while (!fwd_ready && g < 50) begin
         step();
         g++;
      end
      chk("fwd_rdy", 32'(fwd_ready), 32'd1);
      chk("cap_grad_rdy", 32'(grad_ready), 32'd0);
      step();
      fwd_valid = 1'b0;
   endtask

   task automatic push_grad(input logic [N-1:0] gv);
      int g = 0;
      grad_valid = 1'b1;
      grad_in    = gv;
      while (!grad_ready && g < 50) begin
         step();
         g++;
      end
      chk("grad_rdy", 32'(grad_ready), 32'd1);
      step();
      grad_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int g = 0;
      while (done_n == d0 && g < 300) begin
         step();
         g++;
      end
      repeat (2) step();
      chk("done_once", 32'(done_n - d0), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("sb_empty", 32'(eq.size()), 32'd0);
   endtask

   initial begin
      int d0, g0, o0, sent, k;
      logic x;
      logic [3:0] pat;

      rst_n = 1'b0; start = 1'b0; len = '0; fwd_valid = 1'b0; fwd_x = '0;
      grad_valid = 1'b0; grad_in = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Basic vector: +1.0, -1.0, 0, smallest positive.
      out_ready = 1'b1;
      d0 = done_n; o0 = out_n;
      do_start(7'd4);
      push_fwd(32'h0000_8000);
      push_fwd(32'hFFFF_8000);
      push_fwd(32'h0000_0000);
      push_fwd(32'h0000_0001);
      for (int i = 0; i < 4; i++) push_grad(32'h0001_0000);
      wait_done(d0);
      chk("t1_outs", 32'(out_n - o0), 32'd4);

      // Full-depth vector, back-to-back gradients, extra grad_valid afterwards.
      d0 = done_n; o0 = out_n; g0 = grad_n;
      do_start(7'd64);
      for (int i = 0; i < DEPTH; i++)
         push_fwd((i % 2 == 0) ? 32'(i + 1) : 32'(-(i + 1)));
      for (int i = 0; i < DEPTH; i++) push_grad(32'hA500_0000 + 32'(i));
      grad_valid = 1'b1;
      repeat (5) step();
      grad_valid = 1'b0;
      wait_done(d0);
      chk("t2_grads", 32'(grad_n - g0), 32'd64);
      chk("t2_outs", 32'(out_n - o0), 32'd64);
      chk("t2_streak", 32'(streak), 32'd64);

      // Downstream stalls with out_ready pattern 1,0,0,1.
      pat = 4'b1001;
      d0 = done_n; o0 = out_n;
      do_start(7'd4);
      for (int i = 0; i < 4; i++) push_fwd(32'h0000_0100 + 32'(i));
      sent = 0; k = 0;
      while (sent < 4 && k < 100) begin
         out_ready  = pat[k % 4];
         grad_valid = 1'b1;
         grad_in    = 32'hC0DE_0000 + 32'(sent);
         #1;
         x = grad_ready;
         @(posedge clk);
         #1;
         if (x) sent++;
         k++;
      end
      grad_valid = 1'b0;
      while (done_n == d0 && k < 200) begin
         out_ready = pat[k % 4];
         step();
         k++;
      end
      out_ready = 1'b1;
      wait_done(d0);
      chk("t3_outs", 32'(out_n - o0), 32'd4);

      // Illegal lengths.
      do_start(7'd0);
      chk("len0_err", 32'(err_len), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_fwd_rdy", 32'(fwd_ready), 32'd0);
      step();
      chk("len0_err_clr", 32'(err_len), 32'd0);
      do_start(7'd65);
      chk("len65_err", 32'(err_len), 32'd1);
      chk("len65_busy", 32'(busy), 32'd0);
      chk("len65_fwd_rdy", 32'(fwd_ready), 32'd0);
      step();
      chk("len65_err_clr", 32'(err_len), 32'd0);

      // Reset in the middle of backprop, then a fresh vector.
      do_start(7'd5);
      for (int i = 0; i < 5; i++) push_fwd(32'h0000_0010);
      push_grad(32'h1111_0000);
      push_grad(32'h2222_0000);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      step();
      rst_n = 1'b1;
      step();
      d0 = done_n; o0 = out_n;
      do_start(7'd2);
      push_fwd(32'hFFFF_FFFF);
      push_fwd(32'h7FFF_FFFF);
      push_grad(32'h3333_0000);
      push_grad(32'h4444_0000);
      wait_done(d0);
      chk("t5_outs", 32'(out_n - o0), 32'd2);

      // start and grad_valid during capture must both be ignored.
      d0 = done_n; o0 = out_n; g0 = grad_n;
      grad_valid = 1'b1;
      grad_in    = 32'h0000_1234;
      do_start(7'd3);
      push_fwd(32'h0000_0005);
      start = 1'b1;
      len   = 7'd2;
      step();
      start = 1'b0;
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_grad_hold", 32'(grad_ready), 32'd0);
      push_fwd(32'hFFFF_FFFF);
      push_fwd(32'h0000_0007);
      k = 0;
      while (done_n == d0 && k < 100) begin
         step();
         k++;
      end
      grad_valid = 1'b0;
      wait_done(d0);
      chk("t6_grads", 32'(grad_n - g0), 32'd3);
      chk("t6_outs", 32'(out_n - o0), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
